// File: rtl/skyhop_pkg.sv
// Shared definitions for the skyhop VGA pipeline: bus layout, tile classes and colour key.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

package skyhop_pkg;

  typedef enum logic [1:0] {
    TC_EMPTY  = 2'b00,
    TC_GROUND = 2'b01,
    TC_CLOUD  = 2'b10,
    TC_BONUS  = 2'b11
  } tile_class_t;

  localparam logic [11:0] KEY_RGB = 12'hFFF;

  // Bus layout {vcount[11:0], vsync, hcount[11:0], hsync, rgb[11:0]}
  localparam int VGA_HCOUNT_LSB = 13;
  localparam int VGA_VSYNC_BIT  = 25;
  localparam int VGA_VCOUNT_LSB = 26;

endpackage

// File: rtl/delay.sv
// Fixed-length register delay line with synchronous clear.
module delay #(
  parameter int WIDTH   = 1,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [CLK_DEL];
  logic [WIDTH-1:0] sr_d [CLK_DEL];

  always_comb begin
    sr_d[0] = din;
    for (int k = 1; k < CLK_DEL; k++) sr_d[k] = sr_q[k-1];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CLK_DEL; k++) begin
      if (rst) sr_q[k] <= '0;
      else     sr_q[k] <= sr_d[k];
    end
  end

  assign dout = sr_q[CLK_DEL-1];

endmodule

// File: rtl/draw_layer_tiled.sv
// Overlays one centred row of sprite tiles onto the VGA bus, with map/position shadowed
// at frame start and a frame-counted blink for bonus tiles.
module draw_layer_tiled #(
  parameter int          BLOCKS_N     = 7,
  parameter int          BLOCK_WIDTH  = 80,
  parameter int          BLOCK_HEIGHT = 25,
  parameter int          SCREEN_WIDTH = 800,
  parameter int          OFFSET_Y     = 100,
  parameter int          AX_W         = 7,
  parameter int          AY_W         = 7,
  parameter int          ROM_LAT      = 1,
  parameter int          BLINK_FRAMES = 16,
  parameter logic [11:0] BONUS_RGB    = 12'hF00,
  parameter logic [11:0] KEY_RGB      = skyhop_pkg::KEY_RGB
) (
  input  logic                      pclk,
  input  logic                      rst,
  input  logic                      module_en,
  input  logic [0:BLOCKS_N-1]       layer_map,
  input  logic [0:BLOCKS_N-1]       block_type,
  input  logic [0:BLOCKS_N-1]       bonus_map,
  input  logic [11:0]               ypos,
  input  logic [11:0]               rgb_pixel_ground,
  input  logic [11:0]               rgb_pixel_cloud,
  input  logic [`VGA_BUS_SIZE-1:0]  vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0]  vga_bus_out,
  output logic [AY_W+AX_W-1:0]      pixel_addr
);
  import skyhop_pkg::*;

  localparam int BUS_W   = `VGA_BUS_SIZE;
  localparam int START_X = (SCREEN_WIDTH - BLOCKS_N*BLOCK_WIDTH)/2 - 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [11:0] vcount_in, hcount_in;
  logic        vsync_in, vs_rise;

  assign vcount_in = vga_bus_in[VGA_VCOUNT_LSB +: 12];
  assign hcount_in = vga_bus_in[VGA_HCOUNT_LSB +: 12];
  assign vsync_in  = vga_bus_in[VGA_VSYNC_BIT];

  logic [0:BLOCKS_N-1] sh_layer_q, sh_layer_d, sh_type_q, sh_type_d, sh_bonus_q, sh_bonus_d;
  logic [11:0]         sh_ypos_q, sh_ypos_d;
  logic                vsync_d_q, vsync_d_d, blink_on_q, blink_on_d;
  logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;

  assign vs_rise = vsync_in & ~vsync_d_q;

  always_comb begin
    vsync_d_d   = vsync_in;
    sh_layer_d  = sh_layer_q;
    sh_type_d   = sh_type_q;
    sh_bonus_d  = sh_bonus_q;
    sh_ypos_d   = sh_ypos_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (vs_rise) begin
      sh_layer_d = layer_map;
      sh_type_d  = block_type;
      sh_bonus_d = bonus_map;
      sh_ypos_d  = ypos;
      if (frame_cnt_q == FC_W'(BLINK_FRAMES-1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_d_q   <= 1'b0;
      sh_layer_q  <= '0;
      sh_type_q   <= '0;
      sh_bonus_q  <= '0;
      sh_ypos_q   <= '0;
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      vsync_d_q   <= vsync_d_d;
      sh_layer_q  <= sh_layer_d;
      sh_type_q   <= sh_type_d;
      sh_bonus_q  <= sh_bonus_d;
      sh_ypos_q   <= sh_ypos_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  // 13-bit compares so a row near the bottom of the 12-bit range cannot wrap into a false hit
  logic [12:0] vy;
  logic        row_hit;

  assign vy      = {1'b0, vcount_in} + 13'(OFFSET_Y);
  assign row_hit = (vy >= {1'b0, sh_ypos_q}) &&
                   (vy <  ({1'b0, sh_ypos_q} + 13'(BLOCK_HEIGHT)));

  logic [BLOCKS_N-1:0] col_hit;
  logic [AX_W-1:0]     tile_rx [BLOCKS_N];

  for (genvar gi = 0; gi < BLOCKS_N; gi++) begin : g_tile
    localparam int X0 = START_X + gi*BLOCK_WIDTH;
    assign col_hit[gi] = ({1'b0, hcount_in} >= 13'(X0)) &&
                         ({1'b0, hcount_in} <  13'(X0 + BLOCK_WIDTH));
    assign tile_rx[gi] = AX_W'(hcount_in - 12'(X0));
  end

  logic [AX_W-1:0]          rel_x;
  logic [AY_W-1:0]          rel_y;
  tile_class_t              tclass;
  logic [AY_W+AX_W-1:0]     pixel_addr_q, pixel_addr_d;

  always_comb begin
    rel_x  = '0;
    rel_y  = '0;
    tclass = TC_EMPTY;
    for (int i = 0; i < BLOCKS_N; i++) begin
      if (row_hit && col_hit[i]) begin
        rel_x = tile_rx[i];
        rel_y = AY_W'(vy - {1'b0, sh_ypos_q});
        if (sh_layer_q[i]) begin
          if (sh_bonus_q[i]) tclass = blink_on_q ? TC_BONUS : TC_EMPTY;
          else               tclass = sh_type_q[i] ? TC_GROUND : TC_CLOUD;
        end
      end
    end
    pixel_addr_d = {rel_y, rel_x};
  end

  // Pixel metadata waits ROM_LAT cycles so it meets the ROM data for the same pixel
  logic [BUS_W+2:0] dl_in, dl_out;
  logic             en_dl;
  tile_class_t      class_dl;
  logic [BUS_W-1:0] bus_dl;

  assign dl_in    = {module_en, tclass, vga_bus_in};
  assign en_dl    = dl_out[BUS_W+2];
  assign class_dl = tile_class_t'(dl_out[BUS_W +: 2]);
  assign bus_dl   = dl_out[BUS_W-1:0];

  delay #(.WIDTH(BUS_W+3), .CLK_DEL(ROM_LAT)) u_delay (
    .clk  (pclk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  logic [11:0]      rgb_sel;
  logic [BUS_W-1:0] vga_bus_out_q, vga_bus_out_d;

  always_comb begin
    rgb_sel = bus_dl[11:0];
    if (en_dl) begin
      case (class_dl)
        TC_GROUND: if (rgb_pixel_ground != KEY_RGB) rgb_sel = rgb_pixel_ground;
        TC_CLOUD:  if (rgb_pixel_cloud  != KEY_RGB) rgb_sel = rgb_pixel_cloud;
        TC_BONUS:  rgb_sel = BONUS_RGB;
        default:   rgb_sel = bus_dl[11:0];
      endcase
    end
    vga_bus_out_d = {bus_dl[BUS_W-1:12], rgb_sel};
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pixel_addr_q  <= '0;
      vga_bus_out_q <= '0;
    end else begin
      pixel_addr_q  <= pixel_addr_d;
      vga_bus_out_q <= vga_bus_out_d;
    end
  end

  assign pixel_addr  = pixel_addr_q;
  assign vga_bus_out = vga_bus_out_q;

endmodule
